// File: rtl/mem_responder_pkg.sv
// Shared types, size encodings and helpers for the mem_responder block.
// The optional alignment check is enabled by defining MEM_RESPONDER_ALIGN_CHECK_EN.
package mem_responder_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Number of bytes moved for an access size; the reserved code behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Left-justify write data so the first byte sent (lowest address) sits in [31:24].
  function automatic logic [DATA_W-1:0] align_wdata(input logic [1:0] sz,
                                                     input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (sz)
      SZ_BYTE: r = {d[7:0], 24'h000000};
      SZ_HALF: r = {d[15:0], 16'h0000};
      default: r = d;
    endcase
    return r;
  endfunction

  // True when a halfword sits on an odd address or a word is not 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [ADDR_W-1:0] addr);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = addr[0];
      default: m = (addr[1:0] != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the control unit (master) and mem_responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
  ;
  logic              MOV;
  logic              RW;
  logic [1:0]        TYPE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DOUT;
  logic              MOC;
  logic              ERR;

  modport master (
    output MOV, RW, TYPE, ADDR, DIN,
    input  DOUT, MOC, ERR
  );

  modport slave (
    input  MOV, RW, TYPE, ADDR, DIN,
    output DOUT, MOC, ERR
  );
endinterface

// File: rtl/mem_array_256x8.sv
// 256x8 single-port storage: synchronous write, combinational read.
// Deliberately has no reset so contents survive a controller reset.
module mem_array_256x8
  import mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [256];

  // Commit one byte on the rising edge when the controller is writing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Byte-serial big-endian memory responder. A request is captured in IDLE,
// optionally delayed WAIT_CYCLES edges, then moved one byte per edge in XFER,
// and acknowledged with a registered MOC in DONE until MOV drops.
// Optional feature: MEM_RESPONDER_ALIGN_CHECK_EN makes misaligned halfword/word
// accesses skip memory entirely and complete with ERR set.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           CLK,
  input  logic           CLR,
  mem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [2:0]        bcnt_q,  bcnt_d;
  logic              rw_q,    rw_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [23:0]       acc_q,   acc_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic              moc_q,   moc_d;
  logic              mis_q,   mis_d;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic              err_q,   err_d;
`endif

  logic              mis_cap_s;
  logic              mem_we_s;
  logic [7:0]        mem_rdata_s;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign mis_cap_s = is_misaligned(bus.TYPE, bus.ADDR);
`else
  assign mis_cap_s = 1'b0;
`endif

  mem_array_256x8 u_mem (
    .clk   (CLK),
    .we    (mem_we_s),
    .addr  (addr_q),
    .wdata (wdata_q[31:24]),
    .rdata (mem_rdata_s)
  );

  // Next-state, capture, byte steering and completion flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    moc_d    = moc_q;
    mis_d    = mis_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    mem_we_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.MOV) begin
          rw_d    = bus.RW;
          addr_d  = bus.ADDR;
          wdata_d = align_wdata(bus.TYPE, bus.DIN);
          bcnt_d  = size_bytes(bus.TYPE);
          acc_d   = 24'h000000;
          mis_d   = mis_cap_s;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES != 32'd0) begin
            state_d = WAIT;
          end else if (mis_cap_s) begin
            state_d = DONE;
            moc_d   = 1'b1;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (mis_q) begin
            state_d = DONE;
            moc_d   = 1'b1;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = WAIT;
        end
      end

      XFER: begin
        // Lowest address carries the most significant byte: shift data through
        // the top byte for writes and accumulate from the bottom for reads.
        mem_we_s = ~rw_q;
        addr_d   = addr_q + 8'd1;
        wdata_d  = {wdata_q[23:0], 8'h00};
        bcnt_d   = bcnt_q - 3'd1;
        if (rw_q) begin
          acc_d = {acc_q[15:0], mem_rdata_s};
        end else begin
          acc_d = acc_q;
        end
        if (bcnt_q == 3'd1) begin
          state_d = DONE;
          moc_d   = 1'b1;
          if (rw_q) begin
            dout_d = {acc_q, mem_rdata_s};
          end else begin
            dout_d = dout_q;
          end
        end else begin
          state_d = XFER;
        end
      end

      DONE: begin
        if (!bus.MOV) begin
          state_d = IDLE;
          moc_d   = 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves the storage array untouched.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bcnt_q  <= 3'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 32'h00000000;
      acc_q   <= 24'h000000;
      dout_q  <= 32'h00000000;
      moc_q   <= 1'b0;
      mis_q   <= 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      mis_q   <= mis_d;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.MOC  = moc_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign bus.ERR  = err_q;
`else
  assign bus.ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. dut_a uses WAIT_CYCLES=2, dut_b uses 0.
// Latencies are counted in rising edges with the capture edge as edge 1.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk;
  logic clr;
  int   tests;
  int   fails;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.WAIT_CYCLES(2)) dut_a (.CLK(clk), .CLR(clr), .bus(bus_a));
  mem_responder #(.WAIT_CYCLES(0)) dut_b (.CLK(clk), .CLR(clr), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d, input logic mov, input logic rw, input logic [1:0] typ,
                       input logic [7:0] addr, input logic [31:0] din);
    if (!d) begin
      bus_a.MOV = mov; bus_a.RW = rw; bus_a.TYPE = typ; bus_a.ADDR = addr; bus_a.DIN = din;
    end else begin
      bus_b.MOV = mov; bus_b.RW = rw; bus_b.TYPE = typ; bus_b.ADDR = addr; bus_b.DIN = din;
    end
  endtask

  function automatic logic get_moc(input bit d);
    return d ? bus_b.MOC : bus_a.MOC;
  endfunction

  // Issue one request (called on a falling edge), wait for MOC, optionally keep
  // MOV high for `hold` more edges, then drop MOV and expect MOC to fall.
  task automatic run_op(input bit d, input logic rw, input logic [1:0] typ, input logic [7:0] addr,
                        input logic [31:0] din, input bit scramble, input int hold,
                        output int edges, output logic [31:0] dout, output logic err);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    drive(d, 1'b1, rw, typ, addr, din);
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (scramble && edges == 1) drive(d, 1'b1, 1'b0, SZ_BYTE, 8'h00, 32'hFFFFFFFF);
      if (get_moc(d)) seen = 1'b1;
    end
    if (!seen) check("moc_timeout", 32'(get_moc(d)), 32'd1);
    dout = d ? bus_b.DOUT : bus_a.DOUT;
    err  = d ? bus_b.ERR  : bus_a.ERR;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("moc_held", 32'(get_moc(d)), 32'd1);
    end
    drive(d, 1'b0, rw, typ, addr, din);
    @(posedge clk);
    @(negedge clk);
    check("moc_fall", 32'(get_moc(d)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e;
    logic [31:0] dv;
    logic        er;
    int          moc_cnt;
    int          first_hi;

    tests = 0;
    fails = 0;
    clr   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, SZ_BYTE, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, SZ_BYTE, 8'h00, 32'h0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_dout", bus_a.DOUT, 32'h0);
    check("rst_moc",  32'(bus_a.MOC), 32'd0);
    check("rst_err",  32'(bus_a.ERR), 32'd0);
    check("rst_moc_b", 32'(bus_b.MOC), 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Preload DE AD BE EF at 152 by a word write: 1+2+4 = 7 edges
    run_op(1'b0, 1'b0, SZ_WORD, 8'd152, 32'hDEADBEEF, 1'b0, 0, e, dv, er);
    check("wr152_lat", e, 32'd7);
    check("wr152_mem", {dut_a.u_mem.mem[152], dut_a.u_mem.mem[153],
                        dut_a.u_mem.mem[154], dut_a.u_mem.mem[155]}, 32'hDEADBEEF);

    // Word read 152
    run_op(1'b0, 1'b1, SZ_WORD, 8'd152, 32'h0, 1'b0, 0, e, dv, er);
    check("rd152_lat", e, 32'd7);
    check("rd152_dout", dv, 32'hDEADBEEF);
    check("rd152_err", 32'(er), 32'd0);

    // Word write AABBCCDD at 0; DOUT must keep the last read value
    run_op(1'b0, 1'b0, SZ_WORD, 8'd0, 32'hAABBCCDD, 1'b0, 0, e, dv, er);
    check("wr0_dout_hold", dv, 32'hDEADBEEF);
    check("wr0_mem", {dut_a.u_mem.mem[0], dut_a.u_mem.mem[1],
                      dut_a.u_mem.mem[2], dut_a.u_mem.mem[3]}, 32'hAABBCCDD);

    // Byte write A5 at 255: 1+2+1 = 4 edges
    run_op(1'b0, 1'b0, SZ_BYTE, 8'd255, 32'h000000A5, 1'b0, 0, e, dv, er);
    check("wr255_lat", e, 32'd4);
    check("wr255_mem", 32'(dut_a.u_mem.mem[255]), 32'h000000A5);

    // Halfword read at 255 wraps to address 0
    run_op(1'b0, 1'b1, SZ_HALF, 8'd255, 32'h0, 1'b0, 0, e, dv, er);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    check("rd255_lat", e, 32'd3);
    check("rd255_dout", dv, 32'hDEADBEEF);
    check("rd255_err", 32'(er), 32'd1);
`else
    check("rd255_lat", e, 32'd5);
    check("rd255_dout", dv, 32'h0000A5AA);
    check("rd255_err", 32'(er), 32'd0);
`endif

    // Byte and halfword reads, zero-extended
    run_op(1'b0, 1'b1, SZ_BYTE, 8'd153, 32'h0, 1'b0, 0, e, dv, er);
    check("rd153_lat", e, 32'd4);
    check("rd153_dout", dv, 32'h000000AD);
    run_op(1'b0, 1'b1, SZ_HALF, 8'd154, 32'h0, 1'b0, 0, e, dv, er);
    check("rd154_lat", e, 32'd5);
    check("rd154_dout", dv, 32'h0000BEEF);

    // Inputs changed after capture (to a byte write of FF at 0) must be ignored
    run_op(1'b0, 1'b1, SZ_WORD, 8'd152, 32'h0, 1'b1, 0, e, dv, er);
    check("scr_lat", e, 32'd7);
    check("scr_dout", dv, 32'hDEADBEEF);
    check("scr_mem0", 32'(dut_a.u_mem.mem[0]), 32'h000000AA);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    // Misaligned word read: MOC and ERR after 1+2 edges, no memory access
    run_op(1'b0, 1'b1, SZ_WORD, 8'h02, 32'h0, 1'b0, 0, e, dv, er);
    check("mis_lat", e, 32'd3);
    check("mis_err", 32'(er), 32'd1);
    check("mis_dout", dv, 32'hDEADBEEF);
    check("mis_mem", {dut_a.u_mem.mem[0], dut_a.u_mem.mem[1],
                      dut_a.u_mem.mem[2], dut_a.u_mem.mem[3]}, 32'hAABBCCDD);
    check("mis_err_clr", 32'(bus_a.ERR), 32'd0);
`endif

    // MOV dropped one cycle after capture of a byte read: single MOC pulse at edge 4
    drive(1'b0, 1'b1, 1'b1, SZ_BYTE, 8'd155, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, SZ_BYTE, 8'd155, 32'h0);
    moc_cnt  = 0;
    first_hi = 0;
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_a.MOC) begin
        moc_cnt++;
        if (first_hi == 0) first_hi = k;
      end
    end
    check("drop_moc_cnt", moc_cnt, 32'd1);
    check("drop_moc_edge", first_hi, 32'd4);
    check("drop_dout", bus_a.DOUT, 32'h000000EF);
    check("drop_state", 32'(dut_a.state_q), 32'(IDLE));

    // Word write 12345678 at 0, reset right after the 2nd XFER edge (edge 5)
    drive(1'b0, 1'b1, 1'b0, SZ_WORD, 8'd0, 32'h12345678);
    repeat (5) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("rst_mid_moc", 32'(bus_a.MOC), 32'd0);
    check("rst_mid_dout", bus_a.DOUT, 32'h0);
    check("rst_mid_state", 32'(dut_a.state_q), 32'(IDLE));
    drive(1'b0, 1'b0, 1'b0, SZ_WORD, 8'd0, 32'h12345678);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_mem", {dut_a.u_mem.mem[0], dut_a.u_mem.mem[1],
                          dut_a.u_mem.mem[2], dut_a.u_mem.mem[3]}, 32'h1234CCDD);

    // WAIT_CYCLES=0: every byte access completes in 2 edges, back to back
    run_op(1'b1, 1'b0, SZ_BYTE, 8'd10, 32'h0000003C, 1'b0, 0, e, dv, er);
    check("b_wr10_lat", e, 32'd2);
    run_op(1'b1, 1'b0, SZ_BYTE, 8'd11, 32'h0000005A, 1'b0, 0, e, dv, er);
    check("b_wr11_lat", e, 32'd2);
    run_op(1'b1, 1'b1, SZ_BYTE, 8'd10, 32'h0, 1'b0, 2, e, dv, er);
    check("b_rd10_lat", e, 32'd2);
    check("b_rd10_dout", dv, 32'h0000003C);
    run_op(1'b1, 1'b1, SZ_BYTE, 8'd11, 32'h0, 1'b0, 0, e, dv, er);
    check("b_rd11_lat", e, 32'd2);
    check("b_rd11_dout", dv, 32'h0000005A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 WAIT_CYCLES, 2, number of idle wait cycles inserted between request capture and first byte transfer; legal range 0-15.
REQ-002 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-003 CLR  input  1  reset; asynchronous assertion, active-low, synchronous deassertion handled by the system.
REQ-004 MOV  input  1  memory operation valid, driven by the control unit; held high until MOC is observed.
REQ-005 RW  input  1  1 = read, 0 = write; sampled with MOV.
REQ-006 TYPE  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-007 ADDR  input  8  byte address (low 8 bits of MAR).
REQ-008 DIN  input  32  write data, right-justified for byte/halfword.
REQ-009 DOUT  output  32  read data.
REQ-010 MOC  output  1  memory operation complete.
REQ-011 ERR  output  1  misaligned-access flag (see Configuration).

Function
REQ-012 Storage SHALL be a 256x8 array named mem, big-endian: mem[a] maps to the most significant byte of the access.
REQ-013 FSM states SHALL be IDLE, WAIT, XFER, DONE.
REQ-014 IDLE: on a rising edge with MOV=1, latch RW, TYPE, ADDR, DIN; go to WAIT with counter=WAIT_CYCLES, or directly to XFER if WAIT_CYCLES=0.
REQ-015 WAIT: decrement each edge; go to XFER on the edge where the counter reaches 0.
REQ-016 XFER: transfer exactly one byte per edge (1, 2 or 4 bytes by TYPE); go to DONE after the last byte.
REQ-017 Byte k of an access SHALL use address (ADDR+k) mod 256; wrap-around from 255 to 0 is legal.
REQ-018 Reads: byte zero-extended into DOUT[7:0], halfword into DOUT[15:0], word into DOUT[31:0]; DOUT SHALL update only on the edge entering DONE and hold until the next completed read.
REQ-019 Writes: byte DIN[7:0], halfword DIN[15:0], word DIN[31:0]; each byte commits on its XFER edge.
REQ-020 DONE: MOC=1 (registered); stay in DONE while MOV=1; on the first edge with MOV=0, clear MOC and return to IDLE.
REQ-021 Total latency from capture edge to MOC high SHALL be 1+WAIT_CYCLES+nbytes edges (word, WAIT_CYCLES=2: MOC high 7 edges after capture).
REQ-022 MOV dropping during WAIT/XFER SHALL NOT abort the access; the FSM completes, asserts MOC for exactly one cycle in DONE, then returns to IDLE.
REQ-023 Changes on RW/TYPE/ADDR/DIN after capture SHALL be ignored until the next IDLE capture.
REQ-024 A new request SHALL NOT be accepted in the same edge that leaves DONE; the earliest new capture is the edge after MOC drops.

Reset
REQ-025 CLR=0 SHALL immediately force state=IDLE, MOC=0, DOUT=0, ERR=0, counter=0.
REQ-026 The mem array SHALL NOT be cleared by reset; bytes committed before a mid-operation reset persist and remaining bytes are not written.

Configuration
REQ-027 Macro MEM_RESPONDER_ALIGN_CHECK_EN defined: a halfword with ADDR[0]=1 or a word with ADDR[1:0]!=0 SHALL NOT access memory; the FSM skips XFER, and DONE asserts MOC and ERR together, with DOUT unchanged.
REQ-028 Macro undefined: ERR SHALL be tied 0, and misaligned accesses proceed byte-serially with wrap as in REQ-017.

Structure
REQ-029 Package mem_responder_pkg SHALL hold the state enum, TYPE encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and a function returning byte count per TYPE.
REQ-030 One sub-module, mem_array_256x8 (single-port, synchronous write, combinational read), SHALL hold storage; FSM and byte steering stay in mem_responder.

Verification
REQ-031 Preload mem[152..155]=DE AD BE EF; word read ADDR=152, WAIT_CYCLES=2 -> MOC high 7 edges after capture, DOUT=DEADBEEF.
REQ-032 Byte write DIN=0x000000A5 to ADDR=255, then halfword read ADDR=255 (align check off) -> DOUT=0000A5xx with xx=mem[0], demonstrating wrap.
REQ-033 Word write DIN=12345678 to ADDR=0, reset asserted after 2nd XFER edge -> mem[0..1]=12 34, mem[2..3] unchanged, MOC=0, DOUT=0.
REQ-034 MOV dropped one cycle after capture of a byte read -> MOC pulses high for exactly one cycle, FSM returns to IDLE.
REQ-035 With MEM_RESPONDER_ALIGN_CHECK_EN: word read ADDR=0x02 -> MOC=1 and ERR=1 after 1+WAIT_CYCLES edges, mem untouched, DOUT unchanged.
REQ-036 WAIT_CYCLES=0, back-to-back byte reads with MOV held until MOC -> each MOC after 2 edges, second capture no earlier than the edge after MOC falls.
